y86_dmem_ctl: RTL and testbench
===============================

# y86_dmem_ctl

Parametrised data-memory controller for the Y86-64 pipeline. It replaces the ideal single-cycle byte array in the memory stage with a configurable-depth, configurable-latency, little-endian 64-bit word store behind a valid/ready request and one-cycle response handshake. It flags out-of-range accesses for the pipeline's `SADR` status. The memory stage stalls on `req_ready` and consumes `resp_valid`.

## Interface

Parameters:

- `DEPTH_BYTES`, default 256: size of the byte array. Must be a multiple of 8 and at least 8.
- `LATENCY`, default 2: cycles from request acceptance to response. Must be at least 1.

Ports. Clock and reset: one clock; reset is asynchronous and active-low.

- `CLK` in 1: the single clock. Everything is rising-edge.
- `reset` in 1: asynchronous, active-low reset.

Request and response:

- `req_valid` in 1: request present.
- `req_ready` out 1: controller can accept a request this cycle.
- `req_write` in 1: 1 = write `req_wdata`, 0 = read.
- `req_addr` in 64: byte address of the least-significant byte.
- `req_wdata` in 64: write data.
- `resp_valid` out 1: single-cycle response strobe.
- `resp_rdata` out 64: read data, valid with `resp_valid`.
- `resp_err` out 1: address error, valid with `resp_valid`.

## Operation

**States:** IDLE, WAIT, RESP.

- `req_ready` is 1 in IDLE and in RESP, and 0 in WAIT.
- Accept = `req_valid && req_ready` at a rising edge. On accept the controller latches `req_write`, `req_addr` and `req_wdata`.

**Address check:**

- An access is in range iff `req_addr <= DEPTH_BYTES-8`, compared as full 64-bit unsigned.
- Addresses never wrap. `DEPTH_BYTES-8` is legal; `DEPTH_BYTES-7` is an error; `0xFFFF_FFFF_FFFF_FFF9` is an error.

**Commit edge:** the edge that moves the controller into RESP.

- In-range write: bytes `addr..addr+7` ← `wdata[7:0]..wdata[63:56]`.
- In-range read: `resp_rdata` ← `{mem[addr+7],…,mem[addr]}`.
- Out-of-range access: no array change, `resp_rdata` ← 0, `resp_err` ← 1.
- In-range access: `resp_err` ← 0.
- Write response: `resp_rdata` ← 0.

**Transitions:**

- IDLE, accept, `LATENCY==1`: go to RESP. The commit uses the request inputs directly.
- IDLE, accept, `LATENCY>1`: go to WAIT and load the counter with `LATENCY-2`.
- WAIT: decrement the counter. At 0, go to RESP (commit).
- RESP: `resp_valid`=1 for exactly this cycle.
  - With an accept this cycle, the next state follows the same rule as IDLE.
  - Without an accept, go to IDLE.
- Back-to-back: a request accepted during RESP observes the previous write, because the commit has already happened.

**Sizing and reset:**

- Counter width: `$clog2(LATENCY)`, minimum 1.
- Array contents are not cleared by reset. Reads of never-written bytes are X in simulation.
- Reset mid-access: the in-flight access is discarded. If reset falls before the commit edge, the array is unmodified.

## Timing

- Reset values: state IDLE, `req_ready`=1, `resp_valid`=0, `resp_rdata`=0, `resp_err`=0, counter 0.
- `resp_valid`, `resp_rdata` and `resp_err` are registered outputs. `req_ready` is decoded from the state register only and has no combinational path from any input.
- Latency: a request accepted at edge t gives `resp_valid` high in the cycle after edge t+LATENCY-1, i.e. LATENCY edges after acceptance.
- Throughput: one access per LATENCY cycles. Acceptance during RESP gives zero idle cycles between responses.
- `resp_rdata` and `resp_err` hold their values until the next commit. Consumers sample them only with `resp_valid`.
- There is no response backpressure. The consumer must take `resp_valid` in its single cycle.

## Test plan

- **Reset:** hold `reset`=0 for 3 cycles with `req_valid`=1 → `req_ready`=1, `resp_valid`=0, `resp_rdata`=0, `resp_err`=0. No response appears until a request is accepted after release.
- **Write then read, LATENCY=2, DEPTH=256:**
  - Write `0x0123456789ABCDEF` @ 0x10 → `resp_valid` exactly 2 edges later with `resp_err`=0.
  - Read @ 0x10 issued in the RESP cycle → `0x0123456789ABCDEF`.
  - Byte read @ 0x10 via a read at 0x0F after writing 0 at 0x08 → `resp_rdata[15:8]`=0xEF.
- **Boundary:**
  - Write @ 0xF8 → `resp_err`=0.
  - Write @ 0xF9 → `resp_err`=1 and bytes 0xF8–0xFF unchanged on re-read.
  - Read @ 0xFFFFFFFFFFFFFFF9 → `resp_err`=1, `resp_rdata`=0.
- **LATENCY=1 streaming:** `req_valid` held high for 4 reads → `req_ready` never low; `resp_valid` high for 4 consecutive cycles starting 1 edge after the first accept.
- **LATENCY=4 backpressure:** `req_valid` held high → `req_ready` low for exactly 3 cycles after each accept; `resp_valid` period = 4 cycles.
- **Reset mid-access:** LATENCY=4; write `0xAA..AA` @ 0x20 over prior `0x55..55`; assert reset 2 cycles after accept → re-read returns `0x5555555555555555`, and no `resp_valid` is emitted for the aborted write.

Source files
------------

// File: rtl/y86_dmem_ctl.sv
// Y86-64 data-memory controller: little-endian 64-bit word store behind a
// valid/ready request and a single-cycle registered response, with SADR range check.
module y86_dmem_ctl #(
   parameter int unsigned DEPTH_BYTES = 256,
   parameter int unsigned LATENCY     = 2
) (
   input  logic        CLK,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_write,
   input  logic [63:0] req_addr,
   input  logic [63:0] req_wdata,
   output logic        resp_valid,
   output logic [63:0] resp_rdata,
   output logic        resp_err
);

   localparam int unsigned CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
   localparam int unsigned AW = $clog2(DEPTH_BYTES);
   localparam logic [63:0]    MAX_ADDR = 64'(DEPTH_BYTES - 8);
   localparam logic [CW-1:0]  CNT_LOAD = CW'((LATENCY > 1) ? LATENCY - 2 : 0);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_WAIT = 2'd1,
      S_RESP = 2'd2
   } state_e;

   state_e        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;

   logic          wr_q;
   logic [63:0]   addr_q;
   logic [63:0]   wdata_q;
   logic          resp_valid_q;
   logic [63:0]   resp_rdata_q;
   logic          resp_err_q;

   logic [7:0]    mem [DEPTH_BYTES];

   logic          accept_c;
   logic          commit_c;
   logic          c_write_c;
   logic [63:0]   c_addr_c;
   logic [63:0]   c_wdata_c;
   logic [AW-1:0] idx_c;
   logic          in_range_c;
   logic [63:0]   rd_c;

   // State register
   always_ff @(posedge CLK or negedge reset) begin
      if (!reset) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         S_IDLE, S_RESP: begin
            if (accept_c) begin
               if (LATENCY == 1) begin
                  state_d = S_RESP;
               end else begin
                  state_d = S_WAIT;
                  cnt_d   = CNT_LOAD;
               end
            end else begin
               state_d = S_IDLE;
            end
         end
         S_WAIT: begin
            if (cnt_q == '0) state_d = S_RESP;
            else             cnt_d   = cnt_q - CW'(1);
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Output / commit decode; single-cycle latency commits straight from the request bus
   always_comb begin
      req_ready = (state_q != S_WAIT);
      accept_c  = req_valid && req_ready;
      if (LATENCY == 1) begin
         commit_c  = accept_c;
         c_write_c = req_write;
         c_addr_c  = req_addr;
         c_wdata_c = req_wdata;
      end else begin
         commit_c  = (state_q == S_WAIT) && (cnt_q == '0);
         c_write_c = wr_q;
         c_addr_c  = addr_q;
         c_wdata_c = wdata_q;
      end
      in_range_c = (c_addr_c <= MAX_ADDR);
      idx_c      = c_addr_c[AW-1:0];
      rd_c       = '0;
      for (int k = 0; k < 8; k++) begin
         rd_c[8*k +: 8] = mem[idx_c + AW'(k)];
      end
   end

   // Request latch, response registers and array; reset blocks any commit but never clears the array
   always_ff @(posedge CLK or negedge reset) begin
      if (!reset) begin
         wr_q         <= 1'b0;
         addr_q       <= '0;
         wdata_q      <= '0;
         resp_valid_q <= 1'b0;
         resp_rdata_q <= '0;
         resp_err_q   <= 1'b0;
      end else begin
         resp_valid_q <= (state_d == S_RESP);
         if (accept_c) begin
            wr_q    <= req_write;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
         end
         if (commit_c) begin
            resp_err_q   <= !in_range_c;
            resp_rdata_q <= (in_range_c && !c_write_c) ? rd_c : '0;
            if (in_range_c && c_write_c) begin
               for (int k = 0; k < 8; k++) begin
                  mem[idx_c + AW'(k)] <= c_wdata_c[8*k +: 8];
               end
            end
         end
      end
   end

   assign resp_valid = resp_valid_q;
   assign resp_rdata = resp_rdata_q;
   assign resp_err   = resp_err_q;

endmodule

// File: tb/tb_y86_dmem_ctl.sv
// Bench for y86_dmem_ctl: three instances (LATENCY 2, 1, 4) checked against a byte-array model.
module tb_y86_dmem_ctl;

   localparam int NI    = 3;
   localparam int DEPTH = 256;

   logic CLK = 1'b0;
   always #5 CLK = ~CLK;

   logic [NI-1:0] rst_n;
   logic [NI-1:0] rv, rw, rr, resp_v, resp_e;
   logic [63:0]   ra [NI];
   logic [63:0]   wd [NI];
   logic [63:0]   rd [NI];

   for (genvar g = 0; g < NI; g++) begin : g_dut
      y86_dmem_ctl #(
         .DEPTH_BYTES(DEPTH),
         .LATENCY    ((g == 0) ? 2 : ((g == 1) ? 1 : 4))
      ) u_dut (
         .CLK       (CLK),
         .reset     (rst_n[g]),
         .req_valid (rv[g]),
         .req_ready (rr[g]),
         .req_write (rw[g]),
         .req_addr  (ra[g]),
         .req_wdata (wd[g]),
         .resp_valid(resp_v[g]),
         .resp_rdata(rd[g]),
         .resp_err  (resp_e[g])
      );
   end

   logic [7:0] ref_mem [NI][DEPTH];
   int n_cmp  = 0;
   int n_fail = 0;

   function automatic int lat(int i);
      return (i == 0) ? 2 : ((i == 1) ? 1 : 4);
   endfunction

   task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Issue one access at a negedge; returns at the negedge of the response cycle.
   task automatic access(int i, bit wr, logic [63:0] addr, logic [63:0] data);
      logic [63:0] exp_rd;
      bit          exp_err;
      int          n;
      exp_err = !(addr <= 64'(DEPTH - 8));
      exp_rd  = '0;
      if (!exp_err) begin
         for (int k = 0; k < 8; k++) begin
            if (wr) ref_mem[i][int'(addr[7:0]) + k] = data[8*k +: 8];
            else    exp_rd[8*k +: 8] = ref_mem[i][int'(addr[7:0]) + k];
         end
      end
      check($sformatf("ready_issue[%0d]", i), 64'(rr[i]), 64'd1);
      rv[i] = 1'b1; rw[i] = wr; ra[i] = addr; wd[i] = data;
      @(posedge CLK);
      for (n = 1; n <= 20; n++) begin
         @(negedge CLK);
         rv[i] = 1'b0;
         if (resp_v[i]) break;
         check($sformatf("ready_wait[%0d]", i), 64'(rr[i]), 64'd0);
      end
      check($sformatf("latency[%0d]", i), 64'(n), 64'(lat(i)));
      check($sformatf("ready_resp[%0d]", i), 64'(rr[i]), 64'd1);
      check($sformatf("err[%0d]@%h", i, addr), 64'(resp_e[i]), 64'(exp_err));
      check($sformatf("rdata[%0d]@%h", i, addr), rd[i], exp_rd);
   endtask

   task automatic idle_check(int i);
      @(negedge CLK);
      check($sformatf("no_resp[%0d]", i), 64'(resp_v[i]), 64'd0);
   endtask

   initial begin
      logic [63:0] a, d;
      int          sel;
      rst_n = '0;
      rv    = '1;
      rw    = '1;
      for (int i = 0; i < NI; i++) begin
         ra[i] = 64'h10;
         wd[i] = 64'hDEAD_BEEF_DEAD_BEEF;
      end
      // Reset held with requests pending
      repeat (3) begin
         @(negedge CLK);
         for (int i = 0; i < NI; i++) begin
            check($sformatf("rst_ready[%0d]", i), 64'(rr[i]), 64'd1);
            check($sformatf("rst_valid[%0d]", i), 64'(resp_v[i]), 64'd0);
            check($sformatf("rst_rdata[%0d]", i), rd[i], 64'd0);
            check($sformatf("rst_err[%0d]", i), 64'(resp_e[i]), 64'd0);
         end
      end
      rv    = '0;
      rst_n = '1;
      for (int i = 0; i < NI; i++) idle_check(i);

      // Fill every instance so all later reads are defined
      for (int i = 0; i < NI; i++)
         for (int w = 0; w < DEPTH / 8; w++)
            access(i, 1'b1, 64'(w * 8), {$urandom, $urandom});

      // Directed, LATENCY=2
      access(0, 1'b1, 64'h10, 64'h0123_4567_89AB_CDEF);
      access(0, 1'b0, 64'h10, 64'h0);
      check("rd_word", rd[0], 64'h0123_4567_89AB_CDEF);
      access(0, 1'b1, 64'h08, 64'h0);
      access(0, 1'b0, 64'h0F, 64'h0);
      check("byte_ef", 64'(rd[0][15:8]), 64'hEF);
      access(0, 1'b1, 64'hF8, 64'h1122_3344_5566_7788);
      check("edge_ok", 64'(resp_e[0]), 64'd0);
      access(0, 1'b1, 64'hF9, 64'hFFFF_FFFF_FFFF_FFFF);
      check("edge_err", 64'(resp_e[0]), 64'd1);
      access(0, 1'b0, 64'hF8, 64'h0);
      check("edge_keep", rd[0], 64'h1122_3344_5566_7788);
      access(0, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'h0);
      check("wrap_err", 64'(resp_e[0]), 64'd1);
      idle_check(0);

      // LATENCY=1 streaming reads, then LATENCY=4 back-to-back
      for (int k = 0; k < 4; k++) access(1, 1'b0, 64'(k * 8), 64'h0);
      idle_check(1);
      for (int k = 0; k < 3; k++) access(2, 1'b0, 64'(k * 16), 64'h0);
      idle_check(2);

      // Reset in the middle of a LATENCY=4 write
      access(2, 1'b1, 64'h20, 64'h5555_5555_5555_5555);
      rv[2] = 1'b1; rw[2] = 1'b1; ra[2] = 64'h20; wd[2] = 64'hAAAA_AAAA_AAAA_AAAA;
      @(posedge CLK);
      @(negedge CLK);
      rv[2] = 1'b0;
      @(negedge CLK);
      rst_n[2] = 1'b0;
      @(negedge CLK);
      check("abort_valid", 64'(resp_v[2]), 64'd0);
      rst_n[2] = 1'b1;
      repeat (4) idle_check(2);
      access(2, 1'b0, 64'h20, 64'h0);
      check("abort_keep", rd[2], 64'h5555_5555_5555_5555);

      // Randomized mix
      for (int i = 0; i < NI; i++) begin
         for (int k = 0; k < 30; k++) begin
            sel = int'($urandom_range(0, 9));
            if (sel == 0)      a = {$urandom, $urandom};
            else if (sel == 1) a = 64'(249 + $urandom_range(0, 6));
            else               a = 64'($urandom_range(0, 248));
            d = {$urandom, $urandom};
            access(i, 1'($urandom_range(0, 1)), a, d);
         end
         idle_check(i);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
